parking_gate_ctrl: RTL and testbench

Multi-lane condominium gate controller. It is the parametrised successor of the single-gate car counter. NLANES bidirectional gates share one occupancy counter. Each lane gets its own gate FSM with a passage timeout and lockout. Capacity is reserved at gate-open time, so concurrent lanes can never overfill the lot or drive the count below zero. It sits between the switch/sensor inputs of the board top level and the LED/7-segment display logic.

---
 rtl/parking_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_parking_gate_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Multi-lane gate controller: per-lane entry/exit FSMs sharing one occupancy counter.
// Capacity is reserved when a gate opens, so concurrent lanes can never over- or under-fill the lot.
module parking_gate_ctrl #(
  parameter int NLANES   = 2,
  parameter int CAPACITY = 10,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 8
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NLANES-1:0] req_in,
  input  logic [NLANES-1:0] req_out,
  output logic [CNT_W-1:0]  count,
  output logic [NLANES-1:0] gate_in,
  output logic [NLANES-1:0] gate_out,
  output logic              full,
  output logic              empty,
  output logic [NLANES-1:0] timeout_evt
);

  localparam int SUM_W = CNT_W + 2;
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENTER   = 2'd1;
  localparam logic [1:0] ST_EXIT    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  localparam logic [SUM_W-1:0] CAP_S    = SUM_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]       state [NLANES];
  logic [TMR_W-1:0] timer [NLANES];

  logic [NLANES-1:0] in_open, out_open, in_done, out_done;
  logic [NLANES-1:0] in_cand, out_cand, grant_in, grant_out;
  logic [SUM_W-1:0]  pend_in, pend_out, count_sum;
  logic              can_enter, can_exit;
  logic              sum_unused;

  function automatic logic [SUM_W-1:0] ones(input logic [NLANES-1:0] v);
    ones = '0;
    for (int i = 0; i < NLANES; i++) ones = ones + SUM_W'(v[i]);
  endfunction

  function automatic logic [NLANES-1:0] lowest(input logic [NLANES-1:0] v);
    lowest = v & (~v + NLANES'(1));
  endfunction

  always_comb begin
    in_open  = '0;
    out_open = '0;
    in_done  = '0;
    out_done = '0;
    in_cand  = '0;
    out_cand = '0;
    for (int i = 0; i < NLANES; i++) begin
      in_open[i]  = (state[i] == ST_ENTER);
      out_open[i] = (state[i] == ST_EXIT);
      in_done[i]  = in_open[i] & ~req_in[i];
      out_done[i] = out_open[i] & ~req_out[i];
      in_cand[i]  = (state[i] == ST_IDLE) & req_in[i];
      out_cand[i] = (state[i] == ST_IDLE) & req_out[i] & ~req_in[i];
    end
    // Grants see only pre-edge count and reservations; same-edge completions free nothing yet.
    pend_in   = ones(in_open);
    pend_out  = ones(out_open);
    can_enter = ({2'b00, count} + pend_in) < CAP_S;
    can_exit  = {2'b00, count} > pend_out;
    grant_in  = can_enter ? lowest(in_cand) : '0;
    grant_out = can_exit ? lowest(out_cand) : '0;
    count_sum = {2'b00, count} + ones(in_done) - ones(out_done);
  end

  assign sum_unused = ^count_sum[SUM_W-1:CNT_W];
  assign gate_in    = in_open;
  assign gate_out   = out_open;
  assign full       = (count == CAP_C);
  assign empty      = (count == '0);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      count       <= '0;
      timeout_evt <= '0;
      for (int i = 0; i < NLANES; i++) begin
        state[i] <= ST_IDLE;
        timer[i] <= '0;
      end
    end else begin
      count <= count_sum[CNT_W-1:0];
      for (int i = 0; i < NLANES; i++) begin
        timeout_evt[i] <= 1'b0;
        case (state[i])
          ST_IDLE: begin
            if (grant_in[i]) begin
              state[i] <= ST_ENTER;
              timer[i] <= '0;
            end else if (grant_out[i]) begin
              state[i] <= ST_EXIT;
              timer[i] <= '0;
            end
          end
          ST_ENTER: begin
            if (!req_in[i]) begin
              state[i] <= ST_IDLE;
            end else if (timer[i] == TMR_LAST) begin
              state[i]       <= ST_LOCKOUT;
              timeout_evt[i] <= 1'b1;
            end else begin
              timer[i] <= timer[i] + TMR_W'(1);
            end
          end
          ST_EXIT: begin
            if (!req_out[i]) begin
              state[i] <= ST_IDLE;
            end else if (timer[i] == TMR_LAST) begin
              state[i]       <= ST_LOCKOUT;
              timeout_evt[i] <= 1'b1;
            end else begin
              timer[i] <= timer[i] + TMR_W'(1);
            end
          end
          default: begin
            if (!req_in[i] && !req_out[i]) state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios with literal expectations, then random
// sensor traffic checked every cycle against a lane-occupancy model.
module tb_parking_gate_ctrl;

  localparam int NL  = 3;
  localparam int CAP = 3;
  localparam int CW  = 4;
  localparam int TO  = 8;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic [NL-1:0] req_in = '0;
  logic [NL-1:0] req_out = '0;
  logic [CW-1:0] count;
  logic [NL-1:0] gate_in, gate_out, timeout_evt;
  logic          full, empty;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: lane mode 0 idle, 1 car entering, 2 car leaving, 3 locked; m_open = cycles gate has been open.
  int m_count = 0;
  int m_lane[NL] = '{default: 0};
  int m_open[NL] = '{default: 0};
  bit m_evt[NL]  = '{default: 1'b0};

  parking_gate_ctrl #(.NLANES(NL), .CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_2(clk_2), .reset(reset), .req_in(req_in), .req_out(req_out), .count(count),
    .gate_in(gate_in), .gate_out(gate_out), .full(full), .empty(empty),
    .timeout_evt(timeout_evt)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #2;
  endtask

  always @(posedge clk_2) begin
    int pin, pout, inc, dec, gi, go;
    for (int i = 0; i < NL; i++) m_evt[i] = 1'b0;
    if (reset) begin
      m_count = 0;
      for (int i = 0; i < NL; i++) begin
        m_lane[i] = 0;
        m_open[i] = 0;
      end
    end else begin
      pin = 0; pout = 0; inc = 0; dec = 0; gi = -1; go = -1;
      for (int i = 0; i < NL; i++) begin
        if (m_lane[i] == 1) begin pin++; if (!req_in[i]) inc++; end
        if (m_lane[i] == 2) begin pout++; if (!req_out[i]) dec++; end
        if (gi < 0 && m_lane[i] == 0 && req_in[i]) gi = i;
        if (go < 0 && m_lane[i] == 0 && req_out[i] && !req_in[i]) go = i;
      end
      if (m_count + pin >= CAP) gi = -1;
      if (m_count <= pout) go = -1;
      for (int i = 0; i < NL; i++) begin
        case (m_lane[i])
          0: begin
            if (i == gi) begin m_lane[i] = 1; m_open[i] = 1; end
            else if (i == go) begin m_lane[i] = 2; m_open[i] = 1; end
          end
          1, 2: begin
            if ((m_lane[i] == 1) ? !req_in[i] : !req_out[i]) m_lane[i] = 0;
            else if (m_open[i] == TO) begin m_lane[i] = 3; m_evt[i] = 1'b1; end
            else m_open[i]++;
          end
          default: if (!req_in[i] && !req_out[i]) m_lane[i] = 0;
        endcase
      end
      m_count = m_count + inc - dec;
    end
  end

  always @(negedge clk_2) begin
    logic [NL-1:0] egi, ego, eev;
    if (chk_en) begin
      for (int i = 0; i < NL; i++) begin
        egi[i] = (m_lane[i] == 1);
        ego[i] = (m_lane[i] == 2);
        eev[i] = m_evt[i];
      end
      check("model_count", count, m_count);
      check("model_gate_in", gate_in, egi);
      check("model_gate_out", gate_out, ego);
      check("model_full", full, m_count == CAP);
      check("model_empty", empty, m_count == 0);
      check("model_timeout_evt", timeout_evt, eev);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, e;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_gate_in", gate_in, 0);
    check("rst_gate_out", gate_out, 0);
    check("rst_evt", timeout_evt, 0);
    reset = 1'b0;

    // single entry held for three sampled edges
    req_in = 3'b001; tick();
    check("t1_open", gate_in, 3'b001);
    check("t1_count_open", count, 0);
    tick(); tick();
    req_in = 3'b000; tick();
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    check("t1_closed", gate_in, 0);

    // fill to capacity with contention
    req_in = 3'b001; tick(); req_in = 3'b000; tick();
    check("t2_count2", count, 2);
    req_in = 3'b011; tick();
    check("t2_only_lane0", gate_in, 3'b001);
    tick();
    req_in = 3'b010; tick();
    check("t2_count3", count, 3);
    check("t2_full", full, 1);
    check("t2_lane1_blocked", gate_in, 0);
    repeat (3) begin tick(); check("t2_still_blocked", gate_in, 0); end
    req_in = 3'b000; tick();

    // exits with contention at count 1
    repeat (2) begin req_out = 3'b001; tick(); req_out = 3'b000; tick(); end
    check("t3_count1", count, 1);
    req_out = 3'b011; tick();
    check("t3_only_lane0", gate_out, 3'b001);
    tick();
    req_out = 3'b010; tick();
    check("t3_count0", count, 0);
    check("t3_lane1_wait", gate_out, 0);
    req_in = 3'b100; tick();
    check("t3_entry_l2", gate_in, 3'b100);
    check("t3_lane1_wait2", gate_out, 0);
    req_in = 3'b000; tick();
    check("t3_count_back1", count, 1);
    check("t3_no_same_edge", gate_out, 0);
    tick();
    check("t3_lane1_open", gate_out, 3'b010);
    req_out = 3'b000; tick();
    check("t3_count_end", count, 0);

    // timeout on lane 1
    g = 0; e = 0;
    req_in = 3'b010;
    repeat (12) begin tick(); g += int'(gate_in[1]); e += int'(timeout_evt[1]); end
    check("t4_open_cycles", g, TO);
    check("t4_evt_pulses", e, 1);
    check("t4_count", count, 0);
    check("t4_lockout", gate_in, 0);
    req_in = 3'b000; tick();
    req_in = 3'b010; tick();
    check("t4_reopen", gate_in, 3'b010);
    req_in = 3'b000; tick();
    check("t4_count1", count, 1);

    // release on the timeout edge wins
    req_in = 3'b001;
    repeat (TO) tick();
    check("t4b_open_last", gate_in, 3'b001);
    req_in = 3'b000; tick();
    check("t4b_count", count, 2);
    check("t4b_no_evt", timeout_evt, 0);

    // simultaneous entry and exit completion
    req_in = 3'b001; req_out = 3'b010; tick();
    check("t5_gin", gate_in, 3'b001);
    check("t5_gout", gate_out, 3'b010);
    tick();
    req_in = 3'b000; req_out = 3'b000; tick();
    check("t5_count", count, 2);
    check("t5_gin_closed", gate_in, 0);
    check("t5_gout_closed", gate_out, 0);

    // reset during an open passage
    req_in = 3'b001; tick();
    check("t6_open", gate_in, 3'b001);
    reset = 1'b1; tick();
    check("t6_count", count, 0);
    check("t6_gate", gate_in, 0);
    check("t6_empty", empty, 1);
    reset = 1'b0; req_in = 3'b000; tick();

    // random sensor traffic
    repeat (4000) begin
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(5) == 0) req_in[i] = ~req_in[i];
        if ($urandom_range(5) == 0) req_out[i] = ~req_out[i];
      end
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
